// File: rtl/pulse_period_monitor_if.sv
// Strobe input and health/fault outputs of the pulse period monitor.
// master drives sig; slave is the monitor.
interface pulse_period_monitor_if #(
  parameter int CBITS = 13
);
  logic             sig;
  logic             locked;
  logic             err;
  logic             early;
  logic             late;
  logic [CBITS-1:0] period;
  logic [7:0]       fault_cnt;

  modport master (
    output sig,
    input  locked,
    input  err,
    input  early,
    input  late,
    input  period,
    input  fault_cnt
  );

  modport slave (
    input  sig,
    output locked,
    output err,
    output early,
    output late,
    output period,
    output fault_cnt
  );
endinterface

// File: rtl/pulse_period_monitor.sv
// Locks onto a periodic strobe of N+1 cycles (+/-TOL) and
// reports early/late pulses as fault events once locked.
module pulse_period_monitor #(
  parameter int N        = 5000,
  parameter int CBITS    = 13,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  pulse_period_monitor_if.slave bus
);

  localparam int GBITS = $clog2(LOCK_CNT + 1);

  localparam logic [CBITS-1:0] WIN_LO = CBITS'(N - TOL);
  localparam logic [CBITS-1:0] WIN_HI = CBITS'(N + TOL);
  localparam logic [CBITS-1:0] TO_CNT = CBITS'(N + TOL + 1);
  localparam logic [CBITS-1:0] C_MAX  = '1;
  localparam logic [GBITS-1:0] G_LOCK = GBITS'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCK,
    FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [GBITS-1:0] good_q, good_d;
  logic [CBITS-1:0] period_q, period_d;
  logic [7:0]       fault_q, fault_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             early_q, early_d;
  logic             late_q, late_d;

  logic sig;
  logic in_win;
  logic early_ev;
  logic late_ev;
  logic timeout;
  logic fault_ev;

  assign sig = bus.sig;

  always_comb begin
    in_win   = sig && (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
    early_ev = sig && (cnt_q < WIN_LO);
    late_ev  = sig && (cnt_q > WIN_HI);
    // counter saturates past TO_CNT, so this fires once per gap
    timeout  = !sig && (cnt_q == TO_CNT);
  end

  always_comb begin
    cnt_d    = cnt_q;
    state_d  = state_q;
    good_d   = good_q;
    period_d = period_q;
    fault_d  = fault_q;
    early_d  = 1'b0;
    late_d   = 1'b0;
    fault_ev = 1'b0;

    if (sig) begin
      cnt_d = '0;
    end else if (cnt_q != C_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (sig && (state_q != IDLE)) begin
      period_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (sig) begin
          state_d = ACQ;
          good_d  = '0;
        end
      end
      ACQ: begin
        if (in_win) begin
          if (good_q + 1'b1 == G_LOCK) begin
            state_d = LOCK;
            good_d  = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end else if (early_ev || late_ev) begin
          good_d = '0;
        end else if (timeout) begin
          state_d = IDLE;
          good_d  = '0;
        end
      end
      LOCK: begin
        if (early_ev) begin
          state_d  = FAULT;
          early_d  = 1'b1;
          fault_ev = 1'b1;
        end else if (late_ev || timeout) begin
          state_d  = FAULT;
          late_d   = 1'b1;
          fault_ev = 1'b1;
        end
      end
      FAULT: begin
        if (sig) begin
          state_d = ACQ;
          good_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        good_d  = '0;
      end
    endcase

    if (fault_ev && (fault_q != 8'hff)) begin
      fault_d = fault_q + 1'b1;
    end

    err_d    = early_d | late_d;
    locked_d = (state_d == LOCK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      good_q   <= '0;
      period_q <= '0;
      fault_q  <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      early_q  <= 1'b0;
      late_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      fault_q  <= fault_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      early_q  <= early_d;
      late_q   <= late_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.early     = early_q;
  assign bus.late      = late_q;
  assign bus.period    = period_q;
  assign bus.fault_cnt = fault_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Bench for pulse_period_monitor: vector table, corner sequences
// and random gaps against an elapsed-time reference model.
module tb_pulse_period_monitor;

  localparam int N     = 20;
  localparam int CBITS = 13;
  localparam int TOL   = 2;
  localparam int LCNT  = 4;
  localparam int CMAX  = (1 << CBITS) - 1;

  logic clk;
  logic rst;

  pulse_period_monitor_if #(.CBITS(CBITS)) bus ();

  pulse_period_monitor #(
    .N       (N),
    .CBITS   (CBITS),
    .TOL     (TOL),
    .LOCK_CNT(LCNT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;
  bit mon_en;

  typedef enum int {M_IDLE, M_ACQ, M_LOCK, M_FAULT} mst_t;
  mst_t m_st;
  int   cyc;
  int   last_evt;
  int   m_good;
  int   m_period;
  int   m_fault;
  bit   m_locked;
  bit   m_early;
  bit   m_late;

  typedef struct {
    int gap;
    bit lk;
    bit e;
    bit l;
    int per;
    int fc;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: cnt is just elapsed cycles since the last sig/rst.
  task automatic model_step();
    int c;
    bit win, ev_e, ev_l, to;
    cyc++;
    m_early = 0;
    m_late  = 0;
    if (rst) begin
      m_st = M_IDLE;
      m_good = 0;
      m_period = 0;
      m_fault = 0;
      m_locked = 0;
      last_evt = cyc;
      return;
    end
    c = cyc - last_evt - 1;
    if (c > CMAX) c = CMAX;
    win  = sig_now() && c >= N - TOL && c <= N + TOL;
    ev_e = sig_now() && c < N - TOL;
    ev_l = sig_now() && c > N + TOL;
    to   = !sig_now() && c == N + TOL + 1;
    if (sig_now()) begin
      if (m_st != M_IDLE) m_period = c + 1;
      last_evt = cyc;
    end
    case (m_st)
      M_IDLE: if (sig_now()) begin m_st = M_ACQ; m_good = 0; end
      M_ACQ: begin
        if (win) begin
          m_good++;
          if (m_good == LCNT) begin m_st = M_LOCK; m_good = 0; end
        end else if (ev_e || ev_l) m_good = 0;
        else if (to) begin m_st = M_IDLE; m_good = 0; end
      end
      M_LOCK: begin
        if (ev_e) m_early = 1;
        else if (ev_l || to) m_late = 1;
        if (m_early || m_late) begin
          m_st = M_FAULT;
          if (m_fault < 255) m_fault++;
        end
      end
      default: if (sig_now()) begin m_st = M_ACQ; m_good = 0; end
    endcase
    m_locked = (m_st == M_LOCK);
  endtask

  function automatic bit sig_now();
    return bus.sig;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (mon_en) begin
      tests++;
      if (bus.locked !== m_locked || bus.early !== m_early ||
          bus.late !== m_late || bus.err !== (m_early | m_late) ||
          int'(bus.period) != m_period ||
          int'(bus.fault_cnt) != m_fault) begin
        fails++;
        $display("FAIL model cyc=%0d: got lk=%b e=%b l=%b err=%b per=%0d fc=%0d expected lk=%b e=%b l=%b per=%0d fc=%0d",
                 cyc, bus.locked, bus.early, bus.late, bus.err,
                 bus.period, bus.fault_cnt, m_locked, m_early,
                 m_late, m_period, m_fault);
      end
    end
  endtask

  task automatic pulse(input int gap);
    for (int i = 0; i < gap - 1; i++) begin
      bus.sig = 1'b0;
      tick();
    end
    bus.sig = 1'b1;
    tick();
    bus.sig = 1'b0;
  endtask

  task automatic acquire();
    pulse(1);
    for (int i = 0; i < LCNT; i++) pulse(N + 1);
  endtask

  task automatic chk_flags(input string nm, input int lk, input int e,
                           input int l, input int per, input int fc);
    chk({nm, ".locked"}, int'(bus.locked), lk);
    chk({nm, ".flags"}, int'({bus.err, bus.early, bus.late}),
        ((e | l) << 2) | (e << 1) | l);
    chk({nm, ".period"}, int'(bus.period), per);
    chk({nm, ".fault_cnt"}, int'(bus.fault_cnt), fc);
  endtask

  initial begin
    int prev_fc;
    bit wrapped;
    bit seen;
    tests = 0;
    fails = 0;
    mon_en = 0;
    cyc = 0;
    last_evt = 0;
    m_st = M_IDLE;
    m_good = 0;
    m_period = 0;
    m_fault = 0;

    tbl[0]  = '{21, 1, 0, 0, 21, 0};
    tbl[1]  = '{19, 1, 0, 0, 19, 0};
    tbl[2]  = '{23, 1, 0, 0, 23, 0};
    tbl[3]  = '{24, 0, 0, 1, 24, 1};
    tbl[4]  = '{21, 0, 0, 0, 21, 1};
    tbl[5]  = '{21, 0, 0, 0, 21, 1};
    tbl[6]  = '{21, 0, 0, 0, 21, 1};
    tbl[7]  = '{21, 0, 0, 0, 21, 1};
    tbl[8]  = '{21, 1, 0, 0, 21, 1};
    tbl[9]  = '{17, 0, 1, 0, 17, 2};
    tbl[10] = '{1,  0, 0, 0, 1,  2};
    tbl[11] = '{1,  0, 0, 0, 1,  2};
    tbl[12] = '{21, 0, 0, 0, 21, 2};
    tbl[13] = '{21, 0, 0, 0, 21, 2};
    tbl[14] = '{21, 0, 0, 0, 21, 2};
    tbl[15] = '{21, 1, 0, 0, 21, 2};

    rst = 1'b1;
    bus.sig = 1'b0;
    tick();
    mon_en = 1;
    tick();
    chk_flags("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // acquisition
    for (int i = 0; i < 3; i++) tick();
    pulse(1);
    for (int i = 0; i < LCNT - 1; i++) pulse(N + 1);
    chk("acq.pre_lock", int'(bus.locked), 0);
    pulse(N + 1);
    chk_flags("acq.lock", 1, 0, 0, 21, 0);

    foreach (tbl[i]) begin
      pulse(tbl[i].gap);
      chk_flags($sformatf("vec%0d", i), tbl[i].lk, tbl[i].e,
                tbl[i].l, tbl[i].per, tbl[i].fc);
    end

    // missing pulse: late exactly 24 cycles after the last pulse
    seen = 0;
    for (int k = 1; k <= N + TOL + 1; k++) begin
      tick();
      if (bus.late || bus.err) seen = 1;
    end
    chk("miss.no_early_late", int'(seen), 0);
    tick();
    chk_flags("miss.late", 0, 0, 1, 21, 3);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.err) seen = 1;
    end
    chk("miss.no_second_err", int'(seen), 0);
    pulse(1);
    chk("miss.restart_no_err", int'(bus.err), 0);
    chk("miss.restart_fc", int'(bus.fault_cnt), 3);

    // back-to-back while locked
    acquire();
    chk("b2b.locked", int'(bus.locked), 1);
    pulse(1);
    chk_flags("b2b.early", 0, 1, 0, 1, 4);

    // reset mid-LOCK
    acquire();
    chk("rstlock.locked", int'(bus.locked), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_flags("rstlock.clear", 0, 0, 0, 0, 0);
    for (int i = 0; i < LCNT; i++) pulse(N + 1);
    chk("rstlock.4pulses", int'(bus.locked), 0);
    pulse(N + 1);
    chk("rstlock.5pulses", int'(bus.locked), 1);

    // fault counter saturation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    prev_fc = 0;
    wrapped = 0;
    for (int i = 0; i < 300; i++) begin
      acquire();
      pulse(10);
      if (int'(bus.fault_cnt) < prev_fc) wrapped = 1;
      prev_fc = int'(bus.fault_cnt);
    end
    chk("sat.fault_cnt", int'(bus.fault_cnt), 255);
    chk("sat.no_wrap", int'(wrapped), 0);

    // random gaps and resets against the model
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel <= 5) pulse(int'($urandom_range(N - 2, N + 4)));
      else if (sel == 6) pulse(int'($urandom_range(1, 10)));
      else if (sel == 7) pulse(int'($urandom_range(N + 5, N + 40)));
      else if (sel == 8) pulse(N + 1);
      else begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
